// File: rtl/divider_pkg.sv
// Shared types and constants for the divider controller slice.
package divider_pkg;
   localparam int DIV_W   = 32;
   localparam int MIN_DIV = 2;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;
endpackage

// File: rtl/divider_core.sv
// Divide-by-D counter with the active divisor register and tick/clk_N decode.
module divider_core
   import divider_pkg::*;
#(
   parameter int W           = DIV_W,
   parameter int DEFAULT_DIV = 100_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         busy_next,
   output logic         wrap,
   output logic         tick,
   output logic         clk_N
);

   logic [W-1:0] cnt_reg, cnt_next;
   logic [W-1:0] div_reg, div_next;
   logic         clk_n_reg;

   assign wrap  = enable && (cnt_reg == div_reg - W'(1));
   assign tick  = wrap;
   assign clk_N = clk_n_reg;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear)
         cnt_next = '0;
      else if (enable)
         cnt_next = wrap ? '0 : cnt_reg + W'(1);
      div_next = load ? load_val : div_reg;
   end

   // clk_N is computed from next-cycle state so the register lines up with busy/cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         div_reg   <= W'(DEFAULT_DIV);
         clk_n_reg <= 1'b0;
      end else begin
         cnt_reg   <= cnt_next;
         div_reg   <= div_next;
         clk_n_reg <= busy_next && (cnt_next < (div_next >> 1));
      end
   end

endmodule

// File: rtl/divider_ctrl.sv
// Run/stop sequencing and divisor handshake; divisors only change on period boundaries.
module divider_ctrl
   import divider_pkg::*;
#(
   parameter int W           = DIV_W,
   parameter int DEFAULT_DIV = 100_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         stop,
   input  logic         cfg_valid,
   input  logic [W-1:0] cfg_div,
   output logic         cfg_ready,
   output logic         cfg_err,
   output logic         tick,
   output logic         clk_N,
   output logic         busy
);

   state_t       state_reg;
   logic         busy_reg;
   logic         pending_reg;
   logic [W-1:0] pending_div_reg;
   logic         cfg_err_reg;

   logic wrap, handshake, illegal, apply;
   logic go_run, period_end, busy_next;

   assign cfg_ready = !pending_reg;
   assign cfg_err   = cfg_err_reg;
   assign busy      = busy_reg;

   assign handshake = cfg_valid && cfg_ready;
   assign illegal   = cfg_div < W'(MIN_DIV);
   assign apply     = pending_reg && ((state_reg == IDLE) || wrap);

   // A stop seen on the wrap cycle ends the run at that same boundary.
   assign go_run     = (state_reg == IDLE) && start && !stop;
   assign period_end = wrap && ((state_reg == STOPPING) || ((state_reg == RUN) && stop));
   assign busy_next  = go_run || (busy_reg && !period_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         busy_reg        <= 1'b0;
         pending_reg     <= 1'b0;
         pending_div_reg <= '0;
         cfg_err_reg     <= 1'b0;
      end else begin
         busy_reg <= busy_next;
         case (state_reg)
            IDLE:     if (start && !stop) state_reg <= RUN;
            RUN:      if (stop) state_reg <= wrap ? IDLE : STOPPING;
            STOPPING: if (wrap) state_reg <= IDLE;
            default:  state_reg <= IDLE;
         endcase
         cfg_err_reg <= handshake && illegal;
         if (apply)
            pending_reg <= 1'b0;
         else if (handshake && !illegal) begin
            pending_reg     <= 1'b1;
            pending_div_reg <= cfg_div;
         end
      end
   end

   divider_core #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (busy_reg),
      .clear     (state_reg == IDLE),
      .load      (apply),
      .load_val  (pending_div_reg),
      .busy_next (busy_next),
      .wrap      (wrap),
      .tick      (tick),
      .clk_N     (clk_N)
   );

endmodule

// File: tb/tb_divider_ctrl.sv
// Random and directed stimulus for divider_ctrl checked against a cycle reference model.
module tb_divider_ctrl;

   localparam int W   = 8;
   localparam int DEF = 7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
   logic [W-1:0] cfg_div = '0;
   logic         cfg_ready, cfg_err, tick, clk_n_w, busy;

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model: phase 0=idle 1=run 2=stopping, position in period, active D.
   int m_phase, m_pos, m_d, m_err;
   int m_queue[$];

   divider_ctrl #(.W(W), .DEFAULT_DIV(DEF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .tick      (tick),
      .clk_N     (clk_n_w),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_pos   = 0;
      m_d     = DEF;
      m_err   = 0;
      m_queue.delete();
   endtask

   task automatic check_outputs();
      bit running;
      running = (m_phase != 0);
      check_val("busy",      busy,      running);
      check_val("tick",      tick,      running && (m_pos == m_d - 1));
      check_val("clk_N",     clk_n_w,   running && (m_pos < m_d / 2));
      check_val("cfg_ready", cfg_ready, m_queue.size() == 0);
      check_val("cfg_err",   cfg_err,   m_err);
   endtask

   // Advance the model across one clock edge with the inputs that edge sampled.
   task automatic model_edge(input bit s, input bit p, input bit v, input int d);
      bit running, last, accept, use_new;
      int next_phase;
      running = (m_phase != 0);
      last    = running && (m_pos == m_d - 1);
      accept  = v && (m_queue.size() == 0);
      use_new = (m_queue.size() != 0) && (m_phase == 0 || last);

      next_phase = m_phase;
      if (m_phase == 0 && s && !p)     next_phase = 1;
      else if (m_phase == 1 && p)      next_phase = last ? 0 : 2;
      else if (m_phase == 2 && last)   next_phase = 0;

      m_pos   = (m_phase == 0 || last) ? 0 : m_pos + 1;
      m_phase = next_phase;
      if (use_new) m_d = m_queue.pop_front();
      m_err = accept && (d < 2);
      if (accept) begin
         if (d >= 2) m_queue.push_back(d);
         $display("cfg handshake div=%0d %s at %0t", d, (d < 2) ? "rejected" : "accepted", $time);
      end
   endtask

   task automatic cycle(input bit s, input bit p, input bit v, input int d);
      start     = s;
      stop      = p;
      cfg_valid = v;
      cfg_div   = W'(d);
      check_outputs();
      @(posedge clk);
      #1;
      model_edge(s, p, v, d);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      check_val("rst_busy",  busy,      0);
      check_val("rst_tick",  tick,      0);
      check_val("rst_clk_N", clk_n_w,   0);
      check_val("rst_ready", cfg_ready, 1);
      check_val("rst_err",   cfg_err,   0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      $display("reset applied at %0t", $time);
   endtask

   initial begin
      int r, dv;
      bit aligned;
      model_reset();
      #12;
      check_val("por_busy",  busy,      0);
      check_val("por_clk_N", clk_n_w,   0);
      check_val("por_ready", cfg_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // D=4, then start: 1,1,0,0 pattern with a tick every 4 cycles
      cycle(0, 0, 1, 4);
      idle_cycles(2);
      cycle(1, 0, 0, 0);
      idle_cycles(12);

      // Stop, move to D=5 and restart
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
      cycle(0, 0, 1, 5);
      cycle(1, 0, 0, 0);
      idle_cycles(15);

      // Back to 4 while running, then offer 6 mid-period
      cycle(0, 0, 1, 4);
      idle_cycles(10);
      cycle(0, 0, 1, 6);
      idle_cycles(20);

      // Illegal divisors are refused without touching D
      cycle(0, 0, 1, 1);
      cycle(0, 0, 1, 0);
      idle_cycles(14);

      // D=8, stop at cnt=1, restart attempts while stopping and with stop held
      cycle(0, 0, 1, 8);
      aligned = 0;
      for (int i = 0; i < 40 && !aligned; i++) begin
         if (m_phase == 1 && m_d == 8 && m_pos == 1) aligned = 1;
         else cycle(0, 0, 0, 0);
      end
      check_val("stop_align", aligned, 1);
      cycle(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
      idle_cycles(4);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);

      // Reset mid-run with a divisor queued
      cycle(1, 0, 0, 0);
      idle_cycles(3);
      cycle(0, 0, 1, 9);
      idle_cycles(2);
      do_reset();
      idle_cycles(3);
      cycle(1, 0, 0, 0);
      idle_cycles(2 * DEF + 2);

      // Randomized traffic, including the largest legal divisor
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3)       dv = 255;
         else if (r < 20) dv = $urandom_range(0, 1);
         else             dv = $urandom_range(2, 12);
         if ($urandom_range(0, 799) == 0) do_reset();
         cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4,
               $urandom_range(0, 99) < 15, dv);
      end
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
